// File: rtl/daq_frame_buffer.sv
// Frame-granular FIFO between the DAQ formatter and the TMB link: only complete
// header-to-trailer frames become visible to the reader; short-space frames are dropped whole.
module daq_frame_buffer #(
  parameter int AW        = 11,
  parameter int MAX_WORDS = 800
) (
  input  logic        clk,
  input  logic        hard_rst,
  input  logic [18:0] daqp,
  output logic [18:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        frame_end,
  output logic        frame_err,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_cnt,
  output logic [AW:0] fifo_words
);
  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_STORE    = 2'd1;
  localparam logic [1:0]  S_DROP     = 2'd2;
  localparam logic [AW:0] DEPTH      = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] MAX_FREE   = (AW+1)'(MAX_WORDS);
  localparam logic [10:0] WCNT_LIMIT = 11'(MAX_WORDS - 1);
  localparam logic [7:0]  TRL_TAG    = 8'b00111010;

  logic [18:0]   mem [2**AW];
  logic [1:0]    state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [AW:0]   rd_ptr_q, fetch_ptr_q;
  logic [10:0]   wcnt_q, wcnt_d;
  logic [AW:0]   base_ptr, free_words;
  logic [AW-1:0] wr_addr;
  logic          we, frame_err_d, drop_inc, frame_inc;
  logic          word_ok, is_hdr, is_trl;
  logic [18:0]   ram_q, dout_q;
  logic          ram_valid_q, dout_valid_q, frame_end_q, frame_err_q;
  logic [7:0]    drop_cnt_q, err_cnt_q;
  logic [15:0]   frame_cnt_q;
  logic          take_out, s1_adv, fetch, xfer;

  assign word_ok = !daqp[18];
  assign is_hdr  = word_ok && (daqp[15:0] == 16'hDB0A);
  assign is_trl  = (daqp[18:11] == TRL_TAG);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wcnt_d       = wcnt_q;
    we           = 1'b0;
    frame_err_d  = 1'b0;
    drop_inc     = 1'b0;
    frame_inc    = 1'b0;
    // a header interrupting a frame reclaims the abandoned words before the space test
    base_ptr     = (state_q == S_STORE && is_hdr) ? commit_ptr_q : wr_ptr_q;
    free_words   = DEPTH - (base_ptr - rd_ptr_q);
    wr_addr      = base_ptr[AW-1:0];
    if (is_hdr) begin
      frame_err_d = (state_q == S_STORE);
      if (free_words >= MAX_FREE) begin
        we       = 1'b1;
        wr_ptr_d = base_ptr + PTR_ONE;
        wcnt_d   = 11'd1;
        state_d  = S_STORE;
      end else begin
        wr_ptr_d = base_ptr;
        drop_inc = 1'b1;
        state_d  = S_DROP;
      end
    end else if (state_q == S_STORE && word_ok) begin
      if (is_trl) begin
        we           = 1'b1;
        wr_ptr_d     = wr_ptr_q + PTR_ONE;
        commit_ptr_d = wr_ptr_q + PTR_ONE;
        wcnt_d       = wcnt_q + 11'd1;
        frame_inc    = 1'b1;
        frame_err_d  = (daqp[10:0] != wcnt_q + 11'd1);
        state_d      = S_IDLE;
      end else if (wcnt_q >= WCNT_LIMIT) begin
        wr_ptr_d    = commit_ptr_q;
        frame_err_d = 1'b1;
        state_d     = S_DROP;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        wcnt_d   = wcnt_q + 11'd1;
      end
    end else if (state_q == S_DROP && is_trl) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!hard_rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      wcnt_q       <= '0;
      frame_err_q  <= 1'b0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      wcnt_q       <= wcnt_d;
      frame_err_q  <= frame_err_d;
      if (drop_inc && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Two-stage read pipeline (RAM register, output register) with stall propagation
  assign take_out = !dout_valid_q || dout_ready;
  assign s1_adv   = !ram_valid_q || take_out;
  assign fetch    = s1_adv && (fetch_ptr_q != commit_ptr_q);
  assign xfer     = dout_valid_q && dout_ready;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= daqp;
    if (fetch) ram_q <= mem[fetch_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!hard_rst) begin
      fetch_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      ram_valid_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      if (fetch) fetch_ptr_q <= fetch_ptr_q + PTR_ONE;
      if (s1_adv) ram_valid_q <= fetch;
      if (take_out) begin
        dout_valid_q <= ram_valid_q;
        frame_end_q  <= ram_valid_q && (ram_q[18:11] == TRL_TAG);
        if (ram_valid_q) dout_q <= ram_q;
      end
      if (xfer) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_end  = frame_end_q;
  assign frame_err  = frame_err_q;
  assign drop_cnt   = drop_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign fifo_words = wr_ptr_q - rd_ptr_q;
endmodule
